// File: rtl/ray_march_step.sv
// Sphere-tracing controller: marches one ray through an external SDF stage; optional glow output via MARCH_GLOW_EN.
// Latency: MUL_LAT+ADD_LAT+1+SDF_LAT+ADD_LAT cycles per iteration, up to MAX_STEPS iterations per ray.
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid&out_ready.
module ray_march_step #(
   parameter int          SDF_LAT   = 9,
   parameter int          MUL_LAT   = 2,
   parameter int          ADD_LAT   = 3,
   parameter int          MAX_STEPS = 64,
   parameter int          STEP_W    = 8,
   parameter logic [26:0] EPS       = 27'h1DC0000,
   parameter logic [26:0] T_MAX     = 27'h2090000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [26:0]       in_org_x,
   input  logic [26:0]       in_org_y,
   input  logic [26:0]       in_org_z,
   input  logic [26:0]       in_dir_x,
   input  logic [26:0]       in_dir_y,
   input  logic [26:0]       in_dir_z,
   output logic [26:0]       sdf_px,
   output logic [26:0]       sdf_py,
   output logic [26:0]       sdf_pz,
   input  logic [26:0]       sdf_dist,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_hit,
   output logic [26:0]       out_t,
   output logic [STEP_W-1:0] out_steps
`ifdef MARCH_GLOW_EN
   ,
   output logic [26:0]       out_min_dist
`endif
);

   localparam int PT_LAST  = MUL_LAT + ADD_LAT;
   localparam int SDF_LAST = SDF_LAT - 1;
   localparam int ACC_LAST = ADD_LAT - 1;
   localparam int CNT_W    = $clog2(MUL_LAT + ADD_LAT + SDF_LAT + 2);

   // Float: sign[26], exponent[25:18] bias 127, mantissa[17:0]; zero exponent flushes to zero, truncating.
   function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
      logic [37:0] prod;
      logic [9:0]  e;
      logic [17:0] m;
      prod = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
      e    = {2'b00, a[25:18]} + {2'b00, b[25:18]} - 10'd127 + {9'd0, prod[37]};
      m    = prod[37] ? prod[36:19] : prod[35:18];
      if (a[25:18] == 8'd0 || b[25:18] == 8'd0 || e[9] || e == 10'd0)
         return 27'd0;
      if (e[8])
         e = 10'd255;
      return {a[26] ^ b[26], e[7:0], m};
   endfunction

   function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
      logic [26:0] big;
      logic [26:0] sml;
      logic [7:0]  d;
      logic [20:0] mb;
      logic [20:0] ms;
      logic [21:0] sum;
      logic [9:0]  e;
      logic        found;
      int          lz;
      if (a[25:18] == 8'd0)
         return b;
      if (b[25:18] == 8'd0)
         return a;
      if (a[25:0] >= b[25:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d  = big[25:18] - sml[25:18];
      mb = {1'b1, big[17:0], 2'b00};
      ms = (d > 8'd20) ? 21'd0 : ({1'b1, sml[17:0], 2'b00} >> d);
      e  = {2'b00, big[25:18]};
      if (big[26] == sml[26]) begin
         sum = {1'b0, mb} + {1'b0, ms};
         if (sum[21]) begin
            e = e + 10'd1;
            return {big[26], e[7:0], sum[20:3]};
         end
         return {big[26], e[7:0], sum[19:2]};
      end
      sum = {1'b0, mb - ms};
      if (sum == 22'd0)
         return 27'd0;
      lz    = 0;
      found = 1'b0;
      for (int i = 20; i >= 0; i--) begin
         if (!found) begin
            if (sum[i])
               found = 1'b1;
            else
               lz = lz + 1;
         end
      end
      sum = sum << lz;
      if (e <= 10'(lz))
         return 27'd0;
      e = e - 10'(lz);
      return {big[26], e[7:0], sum[19:2]};
   endfunction

   typedef enum logic [2:0] {IDLE, POINT, SDF, ACCUM, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [26:0]        t;
   logic [26:0]        org [3];
   logic [26:0]        dir [3];
   logic [26:0]        mul_q [3][MUL_LAT];
   logic [26:0]        add_q [3][ADD_LAT];
   logic [26:0]        acc_q [ADD_LAT];
   logic [26:0]        t_new;
   logic               sdf_hit;
   logic               far_exit;
   logic               last_step;

   // Operands stay constant while a state counts down, so free-running pipes suffice.
   always_ff @(posedge clk) begin
      for (int a = 0; a < 3; a++) begin
         mul_q[a][0] <= fp_mul(dir[a], t);
         for (int i = 1; i < MUL_LAT; i++)
            mul_q[a][i] <= mul_q[a][i-1];
         add_q[a][0] <= fp_add(mul_q[a][MUL_LAT-1], org[a]);
         for (int i = 1; i < ADD_LAT; i++)
            add_q[a][i] <= add_q[a][i-1];
      end
      acc_q[0] <= fp_add(t, sdf_dist);
      for (int i = 1; i < ADD_LAT; i++)
         acc_q[i] <= acc_q[i-1];
   end

   assign t_new     = acc_q[ADD_LAT-1];
   assign sdf_hit   = sdf_dist[26] | (sdf_dist[25:0] < EPS[25:0]);
   assign far_exit  = t_new[25:0] > T_MAX[25:0];
   assign last_step = (out_steps + STEP_W'(1)) == STEP_W'(MAX_STEPS);

`ifdef MARCH_GLOW_EN
   logic [26:0] glow_mag;
   assign glow_mag = sdf_dist[26] ? 27'd0 : {1'b0, sdf_dist[25:0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         t         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_t     <= '0;
         out_steps <= '0;
         sdf_px    <= '0;
         sdf_py    <= '0;
         sdf_pz    <= '0;
         for (int a = 0; a < 3; a++) begin
            org[a] <= '0;
            dir[a] <= '0;
         end
`ifdef MARCH_GLOW_EN
         out_min_dist <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  org[0]    <= in_org_x;
                  org[1]    <= in_org_y;
                  org[2]    <= in_org_z;
                  dir[0]    <= in_dir_x;
                  dir[1]    <= in_dir_y;
                  dir[2]    <= in_dir_z;
                  t         <= '0;
                  out_steps <= '0;
                  cnt       <= '0;
                  in_ready  <= 1'b0;
                  state     <= POINT;
`ifdef MARCH_GLOW_EN
                  out_min_dist <= T_MAX;
`endif
               end
            end
            POINT: begin
               if (cnt == CNT_W'(PT_LAST)) begin
                  sdf_px <= add_q[0][ADD_LAT-1];
                  sdf_py <= add_q[1][ADD_LAT-1];
                  sdf_pz <= add_q[2][ADD_LAT-1];
                  cnt    <= '0;
                  state  <= SDF;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SDF: begin
               if (cnt == CNT_W'(SDF_LAST)) begin
                  cnt       <= '0;
                  out_steps <= out_steps + STEP_W'(1);
`ifdef MARCH_GLOW_EN
                  if (glow_mag < out_min_dist)
                     out_min_dist <= glow_mag;
`endif
                  if (sdf_hit || last_step) begin
                     out_hit   <= sdf_hit;
                     out_t     <= t;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= ACCUM;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ACCUM: begin
               if (cnt == CNT_W'(ACC_LAST)) begin
                  cnt <= '0;
                  if (far_exit) begin
                     out_hit   <= 1'b0;
                     out_t     <= t_new;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     t     <= t_new;
                     state <= POINT;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_march_step.sv
// Directed bench for ray_march_step: sphere model and constant-distance stubs driving sdf_dist.
module tb_ray_march_step;

   localparam logic [26:0] F_ZERO   = 27'h0000000;
   localparam logic [26:0] F_ONE    = 27'h1FC0000;
   localparam logic [26:0] F_HALF   = 27'h1F80000;
   localparam logic [26:0] F_1P5    = 27'h1FE0000;
   localparam logic [26:0] F_TWO    = 27'h2000000;
   localparam logic [26:0] F_FOUR   = 27'h2040000;
   localparam logic [26:0] F_TWELVE = 27'h20A0000;
   localparam logic [26:0] F_NEG3   = 27'h6020000;
   localparam logic [26:0] F_NEG1   = 27'h5FC0000;
   localparam logic [26:0] F_NEGQ   = 27'h5F40000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [26:0] in_org_x = '0, in_org_y = '0, in_org_z = '0;
   logic [26:0] in_dir_x = '0, in_dir_y = '0, in_dir_z = '0;
   logic [26:0] sdf_px, sdf_py, sdf_pz;
   logic [26:0] sdf_dist;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_hit;
   logic [26:0] out_t;
   logic [7:0]  out_steps;
`ifdef MARCH_GLOW_EN
   logic [26:0] out_min_dist;
`endif

   logic        stub_en = 1'b0;
   logic [26:0] stub_val = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Unit sphere at the origin, sampled along the z axis only.
   function automatic logic [26:0] sphere_z(input logic [26:0] pz);
      case (pz)
         F_NEG3:  return F_TWO;
         F_NEG1:  return F_ZERO;
         default: return F_FOUR;
      endcase
   endfunction

   assign sdf_dist = stub_en ? stub_val : sphere_z(sdf_pz);

   ray_march_step #(.MAX_STEPS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_org_x(in_org_x), .in_org_y(in_org_y), .in_org_z(in_org_z),
      .in_dir_x(in_dir_x), .in_dir_y(in_dir_y), .in_dir_z(in_dir_z),
      .sdf_px(sdf_px), .sdf_py(sdf_py), .sdf_pz(sdf_pz), .sdf_dist(sdf_dist),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hit(out_hit), .out_t(out_t), .out_steps(out_steps)
`ifdef MARCH_GLOW_EN
      , .out_min_dist(out_min_dist)
`endif
   );

   task automatic send_ray(input logic [26:0] oz, input logic [26:0] dz);
      @(negedge clk);
      in_org_x = F_ZERO; in_org_y = F_ZERO; in_org_z = oz;
      in_dir_x = F_ZERO; in_dir_y = F_ZERO; in_dir_z = dz;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 2000) begin
         @(negedge clk);
         if (!out_valid) cyc++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", out_valid, cyc);
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic check_result(input string name, input logic hit, input logic [26:0] tv, input logic [7:0] st);
      checks++;
      if (out_hit !== hit) begin
         errors++;
         $display("FAIL %s out_hit: got %b, required %b", name, out_hit, hit);
      end
      checks++;
      if (out_t !== tv) begin
         errors++;
         $display("FAIL %s out_t: got %h, required %h", name, out_t, tv);
      end
      checks++;
      if (out_steps !== st) begin
         errors++;
         $display("FAIL %s out_steps: got %0d, required %0d", name, out_steps, st);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
      check_result("reset", 1'b0, F_ZERO, 8'd0);
      checks++;
      if (sdf_pz !== F_ZERO) begin errors++; $display("FAIL reset sdf_pz: got %h, required 0", sdf_pz); end
      rst_n = 1'b1;
   endtask

   task automatic test_sphere_hit;
      int cyc;
      stub_en = 1'b0;
      send_ray(F_NEG3, F_ONE);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy in_ready: got %b, required 0", in_ready); end
      wait_result(cyc);
      checks++;
      if (cyc != 33) begin errors++; $display("FAIL sphere latency: got %0d cycles, required 33", cyc); end
      check_result("sphere", 1'b1, F_TWO, 8'd2);
`ifdef MARCH_GLOW_EN
      checks++;
      if (out_min_dist !== F_ZERO) begin errors++; $display("FAIL sphere min_dist: got %h, required 0", out_min_dist); end
`endif
      consume();
   endtask

   task automatic test_far_plane;
      int cyc;
      stub_en = 1'b1; stub_val = F_FOUR;
      send_ray(F_ZERO, F_ONE);
      wait_result(cyc);
      check_result("far", 1'b0, F_TWELVE, 8'd3);
`ifdef MARCH_GLOW_EN
      checks++;
      if (out_min_dist !== F_FOUR) begin errors++; $display("FAIL far min_dist: got %h, required %h", out_min_dist, F_FOUR); end
`endif
      consume();
   endtask

   task automatic test_max_steps;
      int cyc;
      stub_en = 1'b1; stub_val = F_HALF;
      send_ray(F_ZERO, F_ONE);
      wait_result(cyc);
      check_result("maxsteps", 1'b0, F_1P5, 8'd4);
      consume();
   endtask

   task automatic test_negative_dist;
      int cyc;
      stub_en = 1'b1; stub_val = F_NEGQ;
      send_ray(F_ZERO, F_ONE);
      wait_result(cyc);
      check_result("negative", 1'b1, F_ZERO, 8'd1);
`ifdef MARCH_GLOW_EN
      checks++;
      if (out_min_dist !== F_ZERO) begin errors++; $display("FAIL negative min_dist: got %h, required 0", out_min_dist); end
`endif
      consume();
   endtask

   task automatic test_back_to_back;
      int cyc;
      stub_en = 1'b1; stub_val = F_FOUR;
      send_ray(F_ZERO, F_ONE);
      wait_result(cyc);
      in_org_z = F_NEG3; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_hit !== 1'b0 || out_t !== F_TWELVE || out_steps !== 8'd3) begin
            errors++;
            $display("FAIL hold cycle %0d: valid=%b hit=%b t=%h steps=%0d, required 1 0 %h 3",
                     i, out_valid, out_hit, out_t, out_steps, F_TWELVE);
         end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL hold in_ready cycle %0d: got %b, required 0", i, in_ready); end
      end
      in_valid = 1'b0;
      consume();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL handshake out_valid: got %b, required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL handshake in_ready: got %b, required 1", in_ready); end
      stub_val = F_HALF;
      send_ray(F_ZERO, F_ONE);
      wait_result(cyc);
      check_result("next ray", 1'b0, F_1P5, 8'd4);
      consume();
   endtask

   task automatic test_reset_mid_ray;
      int cyc;
      stub_en = 1'b1; stub_val = F_FOUR;
      send_ray(F_ZERO, F_ONE);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b, required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b, required 0", out_valid); end
      checks++;
      if (sdf_pz !== F_ZERO) begin errors++; $display("FAIL midreset sdf_pz: got %h, required 0", sdf_pz); end
      @(negedge clk);
      rst_n = 1'b1;
      stub_en = 1'b0;
      send_ray(F_NEG3, F_ONE);
      wait_result(cyc);
      check_result("after reset", 1'b1, F_TWO, 8'd2);
      consume();
   endtask

   initial begin
      test_reset();
      test_sphere_hit();
      test_far_plane();
      test_max_steps();
      test_negative_dist();
      test_back_to_back();
      test_reset_mid_ray();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
